slam_stage_sched: RTL and testbench

//   Parametrised stage scheduler between the PS command interface and the RSA/NonLinear core.

---
 rtl/slam_stage_sched.sv | 150 +++++++++++++++
 tb/tb_slam_stage_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slam_stage_sched.sv
// Stage scheduler between the PS command port and the RSA/NonLinear core: a command FIFO,
// one-at-a-time stage issue with angle conversion, a per-stage watchdog, error flags and a done counter.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | no stage outstanding; pops the FIFO head when one is queued
//  ACTIVE | stage_val held, waiting for the matching stage_rdy or watchdog
module slam_stage_sched #(
   parameter int DW      = 32,
   parameter int ANG_W   = 17,
   parameter int ANG_MSB = 19,
   parameter int DEPTH   = 4,
   parameter int FAW     = 2,
   parameter int TO_W    = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             sys_rst,
   input  logic             cmd_val,
   output logic             cmd_rdy,
   input  logic [1:0]       cmd_stage,
   input  logic [DW-1:0]    cmd_a,
   input  logic [DW-1:0]    cmd_b,
   output logic [2:0]       stage_val,
   input  logic [2:0]       stage_rdy,
   output logic [DW-1:0]    op_a,
   output logic [ANG_W-1:0] op_b,
   output logic             busy,
   input  logic [TO_W-1:0]  timeout_lim,
   input  logic             err_clr,
   output logic             err_timeout,
   output logic             err_bad_cmd,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state, state_nxt;

   logic [1:0]    fifo_stage [DEPTH];
   logic [DW-1:0] fifo_a     [DEPTH];
   logic [DW-1:0] fifo_b     [DEPTH];
   logic [FAW:0]  wr_ptr, rd_ptr;
   logic [FAW-1:0] rd_idx;
   logic          full, empty;
   logic          accept, push, bad, pop;
   logic          stage_done, wd_expire;
   logic [TO_W-1:0] wd_cnt;

   assign rd_idx  = rd_ptr[FAW-1:0];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[FAW] != rd_ptr[FAW]) && (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]);
   assign cmd_rdy = !full && !sys_rst;
   assign accept  = cmd_val && cmd_rdy;
   assign push    = accept && (cmd_stage != 2'd3);
   assign bad     = accept && (cmd_stage == 2'd3);
   assign busy    = (state == ACTIVE) || !empty;

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            fifo_stage[wr_ptr[FAW-1:0]] <= cmd_stage;
            fifo_a[wr_ptr[FAW-1:0]]     <= cmd_a;
            fifo_b[wr_ptr[FAW-1:0]]     <= cmd_b;
            wr_ptr                      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Completion is checked first so a stage_rdy landing on the expiry cycle still counts.
   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      stage_done = 1'b0;
      wd_expire  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (|(stage_rdy & stage_val)) begin
               stage_done = 1'b1;
               state_nxt  = IDLE;
            end else if ((timeout_lim != '0) && (wd_cnt == '0)) begin
               wd_expire = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Watchdog counts down from timeout_lim-1 so expiry lands on the timeout_lim-th ACTIVE cycle.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         stage_val   <= '0;
         op_a        <= '0;
         op_b        <= '0;
         wd_cnt      <= '0;
         done_cnt    <= '0;
         err_timeout <= 1'b0;
         err_bad_cmd <= 1'b0;
      end else begin
         if (pop) begin
            stage_val <= 3'b001 << fifo_stage[rd_idx];
            op_a      <= fifo_a[rd_idx];
            op_b      <= {fifo_b[rd_idx][DW-1], fifo_b[rd_idx][ANG_MSB -: ANG_W-1]};
            wd_cnt    <= timeout_lim - 1'b1;
         end else if (stage_done || wd_expire) begin
            stage_val <= '0;
         end else if (state == ACTIVE) begin
            wd_cnt <= wd_cnt - 1'b1;
         end

         if (stage_done) begin
            done_cnt <= done_cnt + 1'b1;
         end

         if (wd_expire) begin
            err_timeout <= 1'b1;
         end else if (err_clr) begin
            err_timeout <= 1'b0;
         end

         if (bad) begin
            err_bad_cmd <= 1'b1;
         end else if (err_clr) begin
            err_bad_cmd <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_slam_stage_sched.sv
// Bench for slam_stage_sched: expected issues are queued when commands are pushed and
// compared when stage_val rises; control/flag behaviour is checked inline.
module tb_slam_stage_sched;

   localparam int DW    = 32;
   localparam int ANG_W = 17;
   localparam int TO_W  = 16;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic             cmd_val = 1'b0;
   logic             cmd_rdy;
   logic [1:0]       cmd_stage = '0;
   logic [DW-1:0]    cmd_a = '0;
   logic [DW-1:0]    cmd_b = '0;
   logic [2:0]       stage_val;
   logic [2:0]       stage_rdy = '0;
   logic [DW-1:0]    op_a;
   logic [ANG_W-1:0] op_b;
   logic             busy;
   logic [TO_W-1:0]  timeout_lim = '0;
   logic             err_clr = 1'b0;
   logic             err_timeout;
   logic             err_bad_cmd;
   logic [CNT_W-1:0] done_cnt;

   slam_stage_sched dut (
      .clk         (clk),
      .sys_rst     (sys_rst),
      .cmd_val     (cmd_val),
      .cmd_rdy     (cmd_rdy),
      .cmd_stage   (cmd_stage),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .stage_val   (stage_val),
      .stage_rdy   (stage_rdy),
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .timeout_lim (timeout_lim),
      .err_clr     (err_clr),
      .err_timeout (err_timeout),
      .err_bad_cmd (err_bad_cmd),
      .done_cnt    (done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]       sv;
      logic [DW-1:0]    a;
      logic [ANG_W-1:0] b;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic [2:0] prev_sv = '0;
   int n_vec = 0;
   int n_err = 0;
   int exp_done = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [ANG_W-1:0] conv(input logic [DW-1:0] b);
      return {b[DW-1], b[19 -: ANG_W-1]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] st, input logic [DW-1:0] a, input logic [DW-1:0] b);
      exp_t e;
      cmd_val   = 1'b1;
      cmd_stage = st;
      cmd_a     = a;
      cmd_b     = b;
      if (st != 2'd3) begin
         e.sv = 3'b001 << st;
         e.a  = a;
         e.b  = conv(b);
         sb.push_back(e);
      end
      tick();
      cmd_val = 1'b0;
   endtask

   task automatic wait_active();
      int k = 0;
      while (stage_val == '0 && k < 50) begin
         tick();
         k++;
      end
      if (stage_val == '0) chk("wait_active_timeout", 64'd0, 64'd1);
   endtask

   task automatic complete(input logic [2:0] rdy);
      stage_rdy = rdy;
      tick();
      stage_rdy = '0;
      exp_done++;
      chk("release_stage_val", stage_val, 3'b000);
      chk("done_cnt", done_cnt, exp_done);
   endtask

   always @(negedge clk) begin
      if (sys_rst) begin
         prev_sv = '0;
      end else begin
         if (stage_val != '0 && prev_sv == '0) begin
            if (sb.size() == 0) begin
               chk("spurious_issue", stage_val, 3'b000);
            end else begin
               mon_e = sb.pop_front();
               chk("issue_stage", stage_val, mon_e.sv);
               chk("issue_op_a", op_a, mon_e.a);
               chk("issue_op_b", op_b, mon_e.b);
            end
         end
         prev_sv = stage_val;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [1:0] t2_st [5];
      int cnt;
      t2_st[0] = 2'd0; t2_st[1] = 2'd1; t2_st[2] = 2'd2; t2_st[3] = 2'd1; t2_st[4] = 2'd0;

      // reset
      tick();
      tick();
      chk("rst_cmd_rdy", cmd_rdy, 1'b0);
      sys_rst = 1'b0;
      tick();
      chk("rst_stage_val", stage_val, 3'b000);
      chk("rst_op_a", op_a, 0);
      chk("rst_op_b", op_b, 0);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_err_timeout", err_timeout, 1'b0);
      chk("rst_err_bad_cmd", err_bad_cmd, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_rdy_after", cmd_rdy, 1'b1);

      // T1 single predict
      push(2'd0, 32'h0001_0000, 32'h0008_0000);
      chk("t1_lat_n1", stage_val, 3'b000);
      tick();
      chk("t1_lat_n2", stage_val, 3'b001);
      chk("t1_op_b", op_b, conv(32'h0008_0000));
      repeat (5) tick();
      chk("t1_held", stage_val, 3'b001);
      complete(3'b001);
      tick();

      // T2 fill FIFO with the core stalled
      for (int i = 0; i < 5; i++) push(t2_st[i], 32'h1000 + i, $urandom);
      chk("t2_cmd_rdy_full", cmd_rdy, 1'b0);
      cmd_val = 1'b1; cmd_stage = 2'd2; cmd_a = 32'hdead; cmd_b = 32'hbeef;
      tick();
      cmd_val = 1'b0;
      chk("t2_busy", busy, 1'b1);
      for (int i = 0; i < 5; i++) begin
         wait_active();
         complete(3'b001 << t2_st[i]);
      end
      tick();
      chk("t2_drained_busy", busy, 1'b0);

      // T3 watchdog
      timeout_lim = 16'd8;
      push(2'd0, 32'h2222, 32'h8001_2340);
      tick();
      cnt = 0;
      while (stage_val != '0 && cnt < 40) begin
         cnt++;
         tick();
      end
      chk("t3_active_cycles", cnt, 8);
      chk("t3_err_timeout", err_timeout, 1'b1);
      chk("t3_done_cnt", done_cnt, exp_done);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t3_err_clr", err_timeout, 1'b0);

      // T4 wrong bit ignored, then completion racing watchdog expiry
      push(2'd1, 32'h3333, 32'h0007_ffff);
      wait_active();
      stage_rdy = 3'b100;
      repeat (3) tick();
      chk("t4_wrong_bit_held", stage_val, 3'b010);
      chk("t4_wrong_bit_done", done_cnt, exp_done);
      stage_rdy = '0;
      repeat (4) tick();
      chk("t4_cycle8_held", stage_val, 3'b010);
      complete(3'b010);
      chk("t4_race_err_timeout", err_timeout, 1'b0);
      timeout_lim = '0;
      tick();

      // T5 illegal command
      push(2'd3, 32'h4444, 32'h5555);
      chk("t5_err_bad_cmd", err_bad_cmd, 1'b1);
      chk("t5_busy", busy, 1'b0);
      repeat (3) tick();
      chk("t5_no_issue", stage_val, 3'b000);
      err_clr = 1'b1;
      push(2'd3, 32'h0, 32'h0);
      err_clr = 1'b0;
      chk("t5_set_wins_clr", err_bad_cmd, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t5_clr", err_bad_cmd, 1'b0);

      // T6 reset mid-operation with two commands queued
      push(2'd3, 32'h0, 32'h0);
      push(2'd2, 32'h6666, 32'h1234_5678);
      push(2'd0, 32'h7777, 32'h0abc_def0);
      push(2'd1, 32'h8888, 32'hfedc_ba98);
      chk("t6_active", stage_val, 3'b100);
      chk("t6_busy_before", busy, 1'b1);
      sys_rst = 1'b1;
      tick();
      sb.delete();
      chk("t6_stage_val", stage_val, 3'b000);
      chk("t6_op_a", op_a, 0);
      chk("t6_op_b", op_b, 0);
      chk("t6_done_cnt", done_cnt, 0);
      chk("t6_err_bad_cmd", err_bad_cmd, 1'b0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_cmd_rdy", cmd_rdy, 1'b0);
      sys_rst = 1'b0;
      repeat (10) tick();
      chk("t6_no_issue_after", stage_val, 3'b000);
      chk("t6_busy_after", busy, 1'b0);

      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
